// File: rtl/parking_pkg.sv
// Shared definitions for the parking-lot controller: door FSM states,
// default parameter values and a population-count helper.
package parking_pkg;

  // Door sequencing states: closed and evaluating, or open and holding.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DOOR = 1'b1
  } door_state_t;

  localparam int DEF_NUM_SPOTS = 8;
  localparam int DEF_TIME_W    = 32;
  localparam int DEF_DOOR_HOLD = 4;
  localparam int DEF_BLINK_DIV = 2;

  // Widest occupancy vector the popcount helper accepts.
  localparam int MAX_SPOTS = 256;

  // Number of set bits; narrower vectors are zero-extended by the caller.
  function automatic int popcount(input logic [MAX_SPOTS-1:0] vec);
    int n;
    n = 0;
    for (int i = 0; i < MAX_SPOTS; i++) begin
      n = n + int'(vec[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/spot_allocator.sv
// Combinational search for the lowest-numbered free spot in the
// occupancy vector; none_free is raised when every spot is taken.
module spot_allocator
  import parking_pkg::*;
#(
  parameter int  NUM_SPOTS = DEF_NUM_SPOTS,
  localparam int IDX_W     = $clog2(NUM_SPOTS)
) (
  input  logic [NUM_SPOTS-1:0] occupied,
  output logic [IDX_W-1:0]     free_idx,
  output logic                 none_free
);

  // Scan from the top down so the last hit, the lowest free index, wins.
  always_comb begin
    free_idx  = '0;
    none_free = 1'b1;
    for (int i = NUM_SPOTS - 1; i >= 0; i--) begin
      if (!occupied[i]) begin
        free_idx  = IDX_W'(i);
        none_free = 1'b0;
      end
    end
  end

endmodule

// File: rtl/parking_lot_ctrl.sv
// Top-level parking-lot controller: door FSM, spot allocation on entry,
// spot release on exit, occupancy/free-count/full status and indicator
// lights. Define PARK_TIMER_EN to build per-spot saturating occupancy
// timers; without it spot_time is tied to zero and no timer flops exist.
module parking_lot_ctrl
  import parking_pkg::*;
#(
  parameter int  NUM_SPOTS = DEF_NUM_SPOTS,
  parameter int  TIME_W    = DEF_TIME_W,
  parameter int  DOOR_HOLD = DEF_DOOR_HOLD,
  parameter int  BLINK_DIV = DEF_BLINK_DIV,
  localparam int IDX_W     = $clog2(NUM_SPOTS),
  localparam int CNT_W     = $clog2(NUM_SPOTS + 1)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        enter,
  input  logic                        exit,
  input  logic [IDX_W-1:0]            exit_spot,
  output logic [NUM_SPOTS-1:0]        occupied,
  output logic [CNT_W-1:0]            free_count,
  output logic                        full,
  output logic                        door_open,
  output logic                        entry_ack,
  output logic [IDX_W-1:0]            entry_spot,
  output logic                        exit_ack,
  output logic                        exit_err,
  output logic                        open_light,
  output logic                        full_light,
  output logic [NUM_SPOTS*TIME_W-1:0] spot_time
);

  localparam int HOLD_W  = $clog2(DOOR_HOLD + 1);
  localparam int BLINK_W = $clog2(BLINK_DIV + 1);

  door_state_t           state_q, state_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
  logic                  open_light_q, open_light_d;
  logic [NUM_SPOTS-1:0]  occupied_q, occupied_d;
  logic [CNT_W-1:0]      free_count_q, free_count_d;
  logic [IDX_W-1:0]      entry_spot_q, entry_spot_d;
  logic                  entry_ack_q, entry_ack_d;
  logic                  exit_ack_q, exit_ack_d;
  logic                  exit_err_q, exit_err_d;

  logic [IDX_W-1:0]      free_idx;
  logic                  none_free;
  logic                  exit_in_range;
  logic                  go_door;
  logic [MAX_SPOTS-1:0]  occ_ext;

  spot_allocator #(
    .NUM_SPOTS (NUM_SPOTS)
  ) u_alloc (
    .occupied  (occupied_q),
    .free_idx  (free_idx),
    .none_free (none_free)
  );

  // Exit indices past the last spot only occur when NUM_SPOTS is not a power of two.
  always_comb begin
    exit_in_range = (int'(exit_spot) < NUM_SPOTS);
  end

  // Door FSM next state plus the allocation/release decision made in IDLE.
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    blink_cnt_d  = blink_cnt_q;
    open_light_d = open_light_q;
    occupied_d   = occupied_q;
    entry_spot_d = entry_spot_q;
    entry_ack_d  = 1'b0;
    exit_ack_d   = 1'b0;
    exit_err_d   = 1'b0;
    go_door      = 1'b0;

    case (state_q)
      IDLE: begin
        open_light_d = 1'b0;
        if (exit) begin
          if (exit_in_range && occupied_q[exit_spot]) begin
            occupied_d[exit_spot] = 1'b0;
            exit_ack_d            = 1'b1;
            go_door               = 1'b1;
          end else begin
            exit_err_d = 1'b1;
          end
        end else if (enter && !none_free) begin
          occupied_d[free_idx] = 1'b1;
          entry_spot_d         = free_idx;
          entry_ack_d          = 1'b1;
          go_door              = 1'b1;
        end

        if (go_door) begin
          state_d      = DOOR;
          hold_cnt_d   = HOLD_W'(1);
          blink_cnt_d  = '0;
          open_light_d = 1'b1;
        end
      end

      DOOR: begin
        if (hold_cnt_q == HOLD_W'(DOOR_HOLD)) begin
          state_d      = IDLE;
          hold_cnt_d   = '0;
          blink_cnt_d  = '0;
          open_light_d = 1'b0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_d  = '0;
            open_light_d = ~open_light_q;
          end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Free count tracks the next occupancy so both update on the same edge.
  always_comb begin
    occ_ext                = '0;
    occ_ext[NUM_SPOTS-1:0] = occupied_d;
    free_count_d           = CNT_W'(NUM_SPOTS - popcount(occ_ext));
  end

  // State, occupancy and pulse registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      hold_cnt_q   <= '0;
      blink_cnt_q  <= '0;
      open_light_q <= 1'b0;
      occupied_q   <= '0;
      free_count_q <= CNT_W'(NUM_SPOTS);
      entry_spot_q <= '0;
      entry_ack_q  <= 1'b0;
      exit_ack_q   <= 1'b0;
      exit_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      open_light_q <= open_light_d;
      occupied_q   <= occupied_d;
      free_count_q <= free_count_d;
      entry_spot_q <= entry_spot_d;
      entry_ack_q  <= entry_ack_d;
      exit_ack_q   <= exit_ack_d;
      exit_err_q   <= exit_err_d;
    end
  end

`ifdef PARK_TIMER_EN
  logic [NUM_SPOTS*TIME_W-1:0] spot_time_q, spot_time_d;

  // Per-spot saturating timers: cleared on allocation, count while occupied, hold after exit.
  always_comb begin
    spot_time_d = spot_time_q;
    for (int i = 0; i < NUM_SPOTS; i++) begin
      if (entry_ack_d && (int'(entry_spot_d) == i)) begin
        spot_time_d[i*TIME_W +: TIME_W] = '0;
      end else if (occupied_q[i] &&
                   (spot_time_q[i*TIME_W +: TIME_W] != {TIME_W{1'b1}})) begin
        spot_time_d[i*TIME_W +: TIME_W] = spot_time_q[i*TIME_W +: TIME_W] + TIME_W'(1);
      end
    end
  end

  // Timer registers share the controller's synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      spot_time_q <= '0;
    end else begin
      spot_time_q <= spot_time_d;
    end
  end

  assign spot_time = spot_time_q;
`else
  assign spot_time = '0;
`endif

  assign occupied   = occupied_q;
  assign free_count = free_count_q;
  assign full       = (free_count_q == '0);
  assign full_light = full;
  assign door_open  = (state_q == DOOR);
  assign entry_ack  = entry_ack_q;
  assign entry_spot = entry_spot_q;
  assign exit_ack   = exit_ack_q;
  assign exit_err   = exit_err_q;
  assign open_light = open_light_q;

endmodule
